// File: rtl/ber_pkg.sv
// Shared types and constants for the PRBS9 bit-error-rate checker.
// Contents: FSM state enum, PRBS9 period, default parameter values,
// relock threshold divider and a helper for the relock error limit.
package ber_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } ber_state_e;

  localparam int unsigned PRBS9_PERIOD  = 511;
  localparam int unsigned DEF_MAX_DELAY = 511;
  localparam int unsigned DEF_ALIGN_LEN = 511;
  localparam int unsigned DEF_CNT_W     = 64;
  localparam int unsigned RELOCK_DIV    = 4;

  // Block error count above which a locked checker restarts its search.
  function automatic int unsigned relock_limit(input int unsigned align_len);
    return align_len / RELOCK_DIV;
  endfunction

endpackage

// File: rtl/ber_delay_line.sv
// Enable-gated shift register of the reference bit with two variable taps.
// tap 0 is the current (undelayed) reference, tap d is the reference from
// d strobes earlier.
// Ports:
//   clock, reset   : clock, asynchronous active-high reset (clears history)
//   shift_en       : advance the history by one strobe
//   ref_bit        : current reference bit
//   sel_a, sel_b   : tap selects (search candidate, locked delay)
//   tap_a_c/tap_b_c: combinational tap outputs
module ber_delay_line #(
  parameter int unsigned MAX_DELAY = 511
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             shift_en,
  input  logic                             ref_bit,
  input  logic [$clog2(MAX_DELAY+1)-1:0]   sel_a,
  input  logic [$clog2(MAX_DELAY+1)-1:0]   sel_b,
  output logic                             tap_a_c,
  output logic                             tap_b_c
);

  localparam int unsigned DW = $clog2(MAX_DELAY + 1);
  localparam int unsigned NT = 1 << DW;

  logic [MAX_DELAY-1:0] sr_q;
  logic [NT-1:0]        taps_c;

  // History register: sr_q[0] is the reference from one strobe ago.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else if (shift_en) begin
      sr_q <= {sr_q[MAX_DELAY-2:0], ref_bit};
    end
  end

  // Pad to a power of two so every select value indexes a defined bit.
  assign taps_c  = NT'({sr_q, ref_bit});
  assign tap_a_c = taps_c[sel_a];
  assign tap_b_c = taps_c[sel_b];

endmodule

// File: rtl/ber_checker.sv
// Receive-side PRBS9 bit-error-rate checker.
// Searches reference delays 0..MAX_DELAY, locks to the one with the fewest
// errors (lowest delay on ties), then accumulates saturating bit/error counts.
// Optional build macro BER_RELOCK_EN: while locked, a block error counter
// restarts the search (keeping counts) when a block is too noisy.
// Ports:
//   clock, i_reset : clock, asynchronous active-high reset
//   i_enable       : baud strobe, one sample per high cycle
//   i_rx_bit       : decided received bit
//   i_ref_bit      : transmitter PRBS9 reference bit
//   i_clear        : synchronous restart of search, clears counters
//   o_locked       : delay selected
//   o_delay        : selected delay
//   o_bits         : compared bits since lock
//   o_errors       : mismatches since lock
module ber_checker
  import ber_pkg::*;
#(
  parameter int unsigned MAX_DELAY = DEF_MAX_DELAY,
  parameter int unsigned ALIGN_LEN = DEF_ALIGN_LEN,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic                           clock,
  input  logic                           i_reset,
  input  logic                           i_enable,
  input  logic                           i_rx_bit,
  input  logic                           i_ref_bit,
  input  logic                           i_clear,
  output logic                           o_locked,
  output logic [$clog2(MAX_DELAY+1)-1:0] o_delay,
  output logic [CNT_W-1:0]               o_bits,
  output logic [CNT_W-1:0]               o_errors
);

  localparam int unsigned DW = $clog2(MAX_DELAY + 1);
  localparam int unsigned WW = $clog2(ALIGN_LEN + 1);

  ber_state_e    state_q, state_d;
  logic [DW-1:0] cand_q;
  logic [DW-1:0] best_d_q;
  logic [WW-1:0] win_cnt_q;
  logic [WW-1:0] win_err_q;
  logic [WW-1:0] best_err_q;

  logic          tap_cand_c, tap_lock_c;
  logic          err_cand_c, err_lock_c;
  logic          step_c;
  logic          search_step_c, lock_step_c, count_step_c;
  logic          win_end_c, search_done_c, better_c;
  logic [WW-1:0] win_err_fin_c;
  logic          bits_sat_c, err_sat_c;
  logic          relock_c;

  ber_delay_line #(
    .MAX_DELAY (MAX_DELAY)
  ) u_delay_line (
    .clock    (clock),
    .reset    (i_reset),
    .shift_en (step_c),
    .ref_bit  (i_ref_bit),
    .sel_a    (cand_q),
    .sel_b    (o_delay),
    .tap_a_c  (tap_cand_c),
    .tap_b_c  (tap_lock_c)
  );

  // Clear wins over the strobe; the reference history only moves on real samples.
  assign step_c        = i_enable & ~i_clear;
  assign err_cand_c    = i_rx_bit ^ tap_cand_c;
  assign err_lock_c    = i_rx_bit ^ tap_lock_c;
  assign win_err_fin_c = win_err_q + WW'(err_cand_c);
  assign better_c      = win_err_fin_c < best_err_q;
  assign bits_sat_c    = &o_bits;
  assign err_sat_c     = &o_errors;

`ifdef BER_RELOCK_EN
  logic [WW-1:0] blk_cnt_q;
  logic [WW-1:0] blk_err_q;
  logic [WW-1:0] blk_err_fin_c;
  logic          blk_end_c;

  assign blk_err_fin_c = blk_err_q + WW'(err_lock_c);
  assign blk_end_c     = lock_step_c && (blk_cnt_q == WW'(ALIGN_LEN - 1));
  assign relock_c      = blk_end_c && (blk_err_fin_c > WW'(relock_limit(ALIGN_LEN)));

  // Block error counter over consecutive ALIGN_LEN locked samples.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      blk_cnt_q <= '0;
      blk_err_q <= '0;
    end else if (i_clear || blk_end_c) begin
      blk_cnt_q <= '0;
      blk_err_q <= '0;
    end else if (lock_step_c) begin
      blk_cnt_q <= blk_cnt_q + WW'(1);
      blk_err_q <= blk_err_fin_c;
    end
  end
`else
  assign relock_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = SEARCH;
    end else begin
      case (state_q)
        SEARCH:  if (search_done_c) state_d = LOCKED;
        LOCKED:  if (relock_c)      state_d = SEARCH;
        default: state_d = SEARCH;
      endcase
    end
  end

  // Per-state datapath controls.
  always_comb begin
    search_step_c = 1'b0;
    lock_step_c   = 1'b0;
    win_end_c     = 1'b0;
    search_done_c = 1'b0;
    case (state_q)
      SEARCH: begin
        search_step_c = step_c;
        win_end_c     = step_c && (win_cnt_q == WW'(ALIGN_LEN - 1));
        search_done_c = win_end_c && (cand_q == DW'(MAX_DELAY));
      end
      LOCKED: begin
        lock_step_c = step_c;
      end
      default: ;
    endcase
    count_step_c = lock_step_c && !bits_sat_c;
  end

  // Search windows, best-delay tracking and saturating accumulators.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      cand_q     <= '0;
      best_d_q   <= '0;
      win_cnt_q  <= '0;
      win_err_q  <= '0;
      best_err_q <= '1;
      o_locked   <= 1'b0;
      o_delay    <= '0;
      o_bits     <= '0;
      o_errors   <= '0;
    end else if (i_clear) begin
      cand_q     <= '0;
      best_d_q   <= '0;
      win_cnt_q  <= '0;
      win_err_q  <= '0;
      best_err_q <= '1;
      o_locked   <= 1'b0;
      o_delay    <= '0;
      o_bits     <= '0;
      o_errors   <= '0;
    end else begin
      if (search_step_c) begin
        if (win_end_c) begin
          win_cnt_q <= '0;
          win_err_q <= '0;
          if (better_c) begin
            best_err_q <= win_err_fin_c;
            best_d_q   <= cand_q;
          end
          if (search_done_c) begin
            cand_q   <= '0;
            o_locked <= 1'b1;
            o_delay  <= better_c ? cand_q : best_d_q;
          end else begin
            cand_q <= cand_q + DW'(1);
          end
        end else begin
          win_cnt_q <= win_cnt_q + WW'(1);
          win_err_q <= win_err_fin_c;
        end
      end
      // Error count freezes once the bit count has saturated.
      if (count_step_c) begin
        o_bits <= o_bits + CNT_W'(1);
        if (err_lock_c && !err_sat_c) begin
          o_errors <= o_errors + CNT_W'(1);
        end
      end
      if (relock_c) begin
        cand_q     <= '0;
        best_d_q   <= '0;
        best_err_q <= '1;
        o_locked   <= 1'b0;
        o_delay    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ber_checker.sv
// Directed self-checking bench for ber_checker (MAX_DELAY=15, ALIGN_LEN=16).
module tb_ber_checker;

  localparam int unsigned MD = 15;
  localparam int unsigned AL = 16;
  localparam int unsigned CW = 64;

  logic          clock;
  logic          i_reset;
  logic          i_enable;
  logic          i_rx_bit;
  logic          i_ref_bit;
  logic          i_clear;
  logic          o_locked;
  logic [3:0]    o_delay;
  logic [CW-1:0] o_bits;
  logic [CW-1:0] o_errors;

  logic [8:0]  lfsr;
  logic [31:0] hist;
  int          checks;
  int          errors;

  ber_checker #(
    .MAX_DELAY (MD),
    .ALIGN_LEN (AL),
    .CNT_W     (CW)
  ) dut (
    .clock     (clock),
    .i_reset   (i_reset),
    .i_enable  (i_enable),
    .i_rx_bit  (i_rx_bit),
    .i_ref_bit (i_ref_bit),
    .i_clear   (i_clear),
    .o_locked  (o_locked),
    .o_delay   (o_delay),
    .o_bits    (o_bits),
    .o_errors  (o_errors)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_locked"}, 64'(o_locked), 64'd0);
    check({tag, "_delay"},  64'(o_delay),  64'd0);
    check({tag, "_bits"},   o_bits,        64'd0);
    check({tag, "_errors"}, o_errors,      64'd0);
  endtask

  // One enabled sample: rx is the reference delayed d strobes, optionally inverted.
  task automatic strobe(input int d, input bit flip, input int gap);
    logic rb;
    logic rx;
    rb        = lfsr[8];
    rx        = (d == 0) ? rb : hist[d-1];
    i_ref_bit = rb;
    i_rx_bit  = rx ^ flip;
    i_enable  = 1'b1;
    @(posedge clock);
    #1;
    i_enable = 1'b0;
    hist     = {hist[30:0], rb};
    lfsr     = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    repeat (gap - 1) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Full search from a fresh start: lock appears exactly after the 256th strobe.
  task automatic search(input int d, input int gap);
    for (int k = 0; k < 255; k++) strobe(d, 1'b0, gap);
    check("prelock", 64'(o_locked), 64'd0);
    strobe(d, 1'b0, gap);
    check("lock", 64'(o_locked), 64'd1);
    check("lock_delay", 64'(o_delay), 64'(d));
  endtask

  // Asynchronous reset pulse between clock edges; history restarts at zero.
  task automatic pulse_reset(input string tag);
    #2;
    i_reset = 1'b1;
    #1;
    check_zero(tag);
    @(posedge clock);
    #1;
    i_reset = 1'b0;
    hist    = '0;
  endtask

  initial begin
    int drop;
    int n;
    checks    = 0;
    errors    = 0;
    lfsr      = 9'h1FF;
    hist      = '0;
    i_reset   = 1'b1;
    i_enable  = 1'b0;
    i_rx_bit  = 1'b0;
    i_ref_bit = 1'b0;
    i_clear   = 1'b0;
    #1;
    check_zero("reset");
    repeat (2) @(posedge clock);
    #1;
    i_reset = 1'b0;

    // Test 1: delay 7, strobe every 4th clock.
    search(7, 4);
    for (int k = 0; k < 1000; k++) strobe(7, 1'b0, 4);
    check("t1_bits", o_bits, 64'd1000);
    check("t1_errors", o_errors, 64'd0);

    // Test 5: enable low for 50 clocks, counts frozen.
    for (int k = 0; k < 50; k++) begin
      @(posedge clock);
      #1;
      check("t5_bits", o_bits, 64'd1000);
      check("t5_errors", o_errors, 64'd0);
    end
    check("t5_locked", 64'(o_locked), 64'd1);

    // Test 4a: clear together with enable; no count, history not advanced.
    i_ref_bit = lfsr[8];
    i_rx_bit  = 1'b1;
    i_clear   = 1'b1;
    i_enable  = 1'b1;
    @(posedge clock);
    #1;
    i_clear  = 1'b0;
    i_enable = 1'b0;
    check_zero("t4_clear");

    // Test 2: relock, then every 10th rx bit inverted.
    search(7, 1);
    for (int k = 0; k < 1000; k++) strobe(7, (k % 10) == 9, 1);
    check("t2_bits", o_bits, 64'd1000);
    check("t2_errors", o_errors, 64'd100);

    // Test 4b: reset mid-count, then mid-search, then full relock.
    pulse_reset("t4_rst_count");
    for (int k = 0; k < 100; k++) strobe(7, 1'b0, 1);
    check("t4_midsearch_locked", 64'(o_locked), 64'd0);
    pulse_reset("t4_rst_search");
    search(7, 1);

    // Test 3: rx equals reference, enable held high.
    pulse_reset("t3_rst");
    search(0, 1);
    for (int k = 0; k < 20; k++) strobe(0, 1'b0, 1);
    check("t3_bits", o_bits, 64'd20);
    check("t3_errors", o_errors, 64'd0);

`ifdef BER_RELOCK_EN
    // Test 6: rx delay jumps from 7 to 3 on a block boundary.
    pulse_reset("t6_rst");
    search(7, 1);
    for (int k = 0; k < 32; k++) strobe(7, 1'b0, 1);
    check("t6_bits_pre", o_bits, 64'd32);
    drop = 0;
    for (int k = 0; k < int'(AL) && o_locked; k++) begin
      strobe(3, 1'b0, 1);
      drop++;
    end
    check("t6_drop", 64'(o_locked), 64'd0);
    check("t6_bits_kept", o_bits, 64'(32 + drop));
    n = 0;
    while (!o_locked && n < 400) begin
      strobe(3, 1'b0, 1);
      n++;
    end
    check("t6_relock", 64'(o_locked), 64'd1);
    check("t6_relock_len", 64'(n), 64'd256);
    check("t6_delay", 64'(o_delay), 64'd3);
    for (int k = 0; k < 10; k++) strobe(3, 1'b0, 1);
    check("t6_bits_post", o_bits, 64'(32 + drop + 10));
`else
    drop = 0;
    n    = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
